rr_apb_arbiter: RTL and testbench

- Round-robin arbiter directly downstream of the per-master request FIFOs fed by the APB slave interconnect.
- Pops one request at a time from N first-word-fall-through FIFOs and issues it to a single shared slave port over a valid/ready handshake.
- Waits for the slave response, then returns read data to the originating channel on the arbiter return path (arb_rdata / arb_rdata_ack).

---
 rtl/rr_apb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rr_apb_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_apb_arbiter.sv
// rr_apb_arbiter: round-robin arbiter that pops N_CH FWFT request FIFOs onto one shared slave port.
// Optional feature macro ARB_TIMEOUT_EN: abandon a request after TIMEOUT cycles and return an error ack.
module rr_apb_arbiter #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [N_CH-1:0]         fifo_empty_i,
  input  logic [N_CH-1:0]         fifo_write_i,
  input  logic [N_CH*AW-1:0]      fifo_addr_i,
  input  logic [N_CH*DW-1:0]      fifo_wdata_i,
  output logic [N_CH-1:0]         fifo_pop_o,
  output logic                    slv_valid_o,
  input  logic                    slv_ready_i,
  output logic                    slv_write_o,
  output logic [AW-1:0]           slv_addr_o,
  output logic [DW-1:0]           slv_wdata_o,
  input  logic                    slv_rvalid_i,
  input  logic [DW-1:0]           slv_rdata_i,
  output logic [N_CH-1:0]         arb_rdata_ack,
  output logic [DW-1:0]           arb_rdata,
  output logic                    arb_err_o,
  output logic [$clog2(N_CH)-1:0] grant_o
);
  localparam int unsigned GW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

  if (N_CH < 2 || N_CH > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("rr_apb_arbiter: N_CH must be 2..8 and TIMEOUT at least 1");
  end

  state_t         state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  grant_d;
  logic [GW-1:0]  pick, cand;
  logic           found;
  logic           write_d;
  logic [AW-1:0]  addr_d;
  logic [DW-1:0]  wdata_d;
  logic [N_CH-1:0] ack_d;
  logic [DW-1:0]  rdata_d;

  logic [AW-1:0]  addr_arr  [N_CH];
  logic [DW-1:0]  wdata_arr [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign addr_arr[k]  = fifo_addr_i[k*AW +: AW];
    assign wdata_arr[k] = fifo_wdata_i[k*DW +: DW];
  end

  // First non-empty channel at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = GW'((32'(ptr_q) + i) % N_CH);
      if (!found && !fifo_empty_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Pop strobe is combinational so the head leaves the FIFO in the grant cycle.
  assign fifo_pop_o = (PRESET && (state_q == IDLE) && found) ? (N_CH'(1) << pick) : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_o;
    write_d = slv_write_o;
    addr_d  = slv_addr_o;
    wdata_d = slv_wdata_o;
    ack_d   = '0;
    rdata_d = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          grant_d = pick;
          ptr_d   = GW'((32'(pick) + 1) % N_CH);
          write_d = fifo_write_i[pick];
          addr_d  = addr_arr[pick];
          wdata_d = wdata_arr[pick];
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (slv_ready_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (slv_rvalid_i) begin
          state_d = RESP;
          ack_d   = N_CH'(1) << grant_o;
          rdata_d = slv_write_o ? '0 : slv_rdata_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    // A response arriving in the expiry cycle still wins over the timeout.
    if ((state_q == ISSUE || state_q == WAIT_RSP) && state_d != RESP) begin
      cnt_d = cnt_q + CW'(1);
      if (32'(cnt_d) >= TIMEOUT) begin
        state_d = RESP;
        ack_d   = N_CH'(1) << grant_o;
        rdata_d = DW'(32'hDEAD_0BAD);
        err_d   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_o       <= '0;
      slv_valid_o   <= 1'b0;
      slv_write_o   <= 1'b0;
      slv_addr_o    <= '0;
      slv_wdata_o   <= '0;
      arb_rdata_ack <= '0;
      arb_rdata     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_o       <= grant_d;
      slv_valid_o   <= (state_d == ISSUE);
      slv_write_o   <= write_d;
      slv_addr_o    <= addr_d;
      slv_wdata_o   <= wdata_d;
      arb_rdata_ack <= ack_d;
      arb_rdata     <= rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      cnt_q     <= '0;
      arb_err_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      arb_err_o <= err_d;
    end
  end
`else
  assign arb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_apb_arbiter.sv
// Directed bench for rr_apb_arbiter: bench-side FIFO contents and a simple slave drive the DUT.
// Expected values are hand-derived per step; the timeout section runs when ARB_TIMEOUT_EN is defined.
module tb_rr_apb_arbiter;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned GW    = 2;
  localparam int          DEPTH = 8;

  logic                PCLK = 1'b0;
  logic                PRESET;
  logic [N_CH-1:0]     fifo_empty_i, fifo_write_i, fifo_pop_o, arb_rdata_ack;
  logic [N_CH*AW-1:0]  fifo_addr_i;
  logic [N_CH*DW-1:0]  fifo_wdata_i;
  logic                slv_valid_o, slv_ready_i, slv_write_o, slv_rvalid_i, arb_err_o;
  logic [AW-1:0]       slv_addr_o;
  logic [DW-1:0]       slv_wdata_o, slv_rdata_i, arb_rdata;
  logic [GW-1:0]       grant_o;

  int checks = 0;
  int errors = 0;

  logic          mem_wr    [N_CH][DEPTH];
  logic [AW-1:0] mem_addr  [N_CH][DEPTH];
  logic [DW-1:0] mem_wdata [N_CH][DEPTH];
  int            head [N_CH];
  int            tail [N_CH];

  int            stall    = 0;
  bit            rsp_en   = 1'b1;
  bit            rsp_pend = 1'b0;
  logic          rsp_wr   = 1'b0;
  logic [AW-1:0] rsp_addr = '0;
  int            cyc      = 0;

  int            pop_ch[$];
  int            pop_cyc[$];
  int            ack_ch[$];
  logic [DW-1:0] ack_data[$];
  logic          ack_err[$];

  always #5 PCLK = ~PCLK;

  rr_apb_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .fifo_empty_i(fifo_empty_i), .fifo_write_i(fifo_write_i),
    .fifo_addr_i(fifo_addr_i), .fifo_wdata_i(fifo_wdata_i), .fifo_pop_o(fifo_pop_o),
    .slv_valid_o(slv_valid_o), .slv_ready_i(slv_ready_i), .slv_write_o(slv_write_o),
    .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
    .slv_rvalid_i(slv_rvalid_i), .slv_rdata_i(slv_rdata_i),
    .arb_rdata_ack(arb_rdata_ack), .arb_rdata(arb_rdata), .arb_err_o(arb_err_o),
    .grant_o(grant_o)
  );

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

  function automatic logic [DW-1:0] rsp_fn(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : ~a;
  endfunction

  function automatic int onehot_idx(input logic [N_CH-1:0] v);
    int r;
    r = -1;
    for (int k = N_CH - 1; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  task automatic push(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_wr[ch][tail[ch] % DEPTH]    = wr;
    mem_addr[ch][tail[ch] % DEPTH]  = a;
    mem_wdata[ch][tail[ch] % DEPTH] = d;
    tail[ch]++;
  endtask

  task automatic refresh();
    for (int k = 0; k < N_CH; k++) begin
      int  s;
      bit  e;
      s = head[k] % DEPTH;
      e = (head[k] == tail[k]);
      fifo_empty_i[k]          = e;
      fifo_write_i[k]          = e ? 1'b0 : mem_wr[k][s];
      fifo_addr_i[k*AW +: AW]  = e ? '0 : mem_addr[k][s];
      fifo_wdata_i[k*DW +: DW] = e ? '0 : mem_wdata[k][s];
    end
  endtask

  task automatic clear_logs();
    pop_ch.delete();
    pop_cyc.delete();
    ack_ch.delete();
    ack_data.delete();
    ack_err.delete();
  endtask

  // One clock: apply pops and slave handshake seen at the edge, then update bench inputs.
  task automatic tick();
    logic [N_CH-1:0] p;
    logic            acc;
    logic [AW-1:0]   a;
    logic            w;
    p   = fifo_pop_o;
    acc = slv_valid_o && slv_ready_i;
    a   = slv_addr_o;
    w   = slv_write_o;
    @(posedge PCLK);
    #1;
    for (int k = 0; k < N_CH; k++) begin
      if (p[k]) begin
        head[k]++;
        pop_ch.push_back(k);
        pop_cyc.push_back(cyc);
      end
    end
    cyc++;
    if (acc) begin
      rsp_pend = 1'b1;
      rsp_addr = a;
      rsp_wr   = w;
    end
    slv_rvalid_i = 1'b0;
    slv_rdata_i  = '0;
    if (rsp_pend && rsp_en) begin
      slv_rvalid_i = 1'b1;
      slv_rdata_i  = rsp_wr ? 32'h5555_5555 : rsp_fn(rsp_addr);
      rsp_pend     = 1'b0;
    end
    slv_ready_i = (stall == 0);
    if (slv_valid_o && stall > 0) stall--;
    if (arb_rdata_ack != '0) begin
      ack_ch.push_back(onehot_idx(arb_rdata_ack));
      ack_data.push_back(arb_rdata);
      ack_err.push_back(arb_err_o);
    end
    refresh();
    #1;
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int n0;
    n0 = ack_ch.size();
    for (int i = 0; i < budget && ack_ch.size() < n0 + n; i++) tick();
    `CHK(tag, ack_ch.size(), n0 + n)
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_d;
    PRESET       = 1'b0;
    slv_ready_i  = 1'b1;
    slv_rvalid_i = 1'b0;
    slv_rdata_i  = '0;
    for (int k = 0; k < N_CH; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    for (int k = 0; k < N_CH; k++) push(k, 1'b0, AW'(32'h100 + k * 4), '0);
    refresh();
    #1;

    // Reset held with every FIFO non-empty
    tick();
    tick();
    `CHK("rst_pop", fifo_pop_o, 4'b0000)
    `CHK("rst_valid", slv_valid_o, 1'b0)
    `CHK("rst_write", slv_write_o, 1'b0)
    `CHK("rst_addr", slv_addr_o, 32'h0)
    `CHK("rst_wdata", slv_wdata_o, 32'h0)
    `CHK("rst_ack", arb_rdata_ack, 4'b0000)
    `CHK("rst_rdata", arb_rdata, 32'h0)
    `CHK("rst_err", arb_err_o, 1'b0)
    `CHK("rst_grant", grant_o, 2'd0)
    `CHK("rst_no_pops", pop_ch.size(), 0)
    PRESET = 1'b1;
    #1;
    `CHK("rel_pop0", fifo_pop_o, 4'b0001)
    wait_acks("rel_drain", 4, 60);
    for (int i = 0; i < 4; i++) begin
      exp_d = ~(32'h100 + 32'(i) * 4);
      checks++;
      if (ack_ch[i] !== i) begin
        errors++;
        $error("FAIL rel_order observed=%0h expected=%0h", ack_ch[i], i);
      end
      checks++;
      if (ack_data[i] !== exp_d) begin
        errors++;
        $error("FAIL rel_data observed=%0h expected=%0h", ack_data[i], exp_d);
      end
    end
    tick();

    // Single read on ch2
    clear_logs();
    push(2, 1'b0, 32'h10, '0);
    refresh();
    #1;
    `CHK("rd_pop", fifo_pop_o, 4'b0100)
    tick();
    `CHK("rd_valid", slv_valid_o, 1'b1)
    `CHK("rd_addr", slv_addr_o, 32'h10)
    `CHK("rd_write", slv_write_o, 1'b0)
    `CHK("rd_grant", grant_o, 2'd2)
    `CHK("rd_pop_once", pop_ch.size(), 1)
    tick();
    `CHK("rd_valid_drop", slv_valid_o, 1'b0)
    `CHK("rd_no_early_ack", arb_rdata_ack, 4'b0000)
    tick();
    `CHK("rd_ack", arb_rdata_ack, 4'b0100)
    `CHK("rd_data", arb_rdata, 32'hDEAD_BEEF)
    `CHK("rd_latency", cyc - pop_cyc[0], 3)
    tick();
    `CHK("rd_ack_clr", arb_rdata_ack, 4'b0000)
    `CHK("rd_data_clr", arb_rdata, 32'h0)
    `CHK("rd_pops_total", pop_ch.size(), 1)

    // Write on ch1 with three stalled cycles
    clear_logs();
    push(1, 1'b1, 32'h20, 32'hA5A5_A5A5);
    stall = 3;
    refresh();
    #1;
    `CHK("wr_pop", fifo_pop_o, 4'b0010)
    for (int i = 0; i < 3; i++) begin
      tick();
      `CHK("wr_valid_hold", slv_valid_o, 1'b1)
      `CHK("wr_write_hold", slv_write_o, 1'b1)
      `CHK("wr_addr_hold", slv_addr_o, 32'h20)
      `CHK("wr_wdata_hold", slv_wdata_o, 32'hA5A5_A5A5)
    end
    wait_acks("wr_ack_seen", 1, 10);
    `CHK("wr_ack", arb_rdata_ack, 4'b0010)
    `CHK("wr_data", arb_rdata, 32'h0)
    tick();

    // Backpressure on ch3 while ch0 empties; next grant skips ch0
    clear_logs();
    push(3, 1'b0, 32'h30, '0);
    push(0, 1'b0, 32'h40, '0);
    stall = 5;
    refresh();
    #1;
    `CHK("bp_pop", fifo_pop_o, 4'b1000)
    for (int i = 0; i < 5; i++) begin
      tick();
      `CHK("bp_valid", slv_valid_o, 1'b1)
      `CHK("bp_addr", slv_addr_o, 32'h30)
      `CHK("bp_grant", grant_o, 2'd3)
      if (i == 2) begin
        tail[0] = head[0];
        push(1, 1'b0, 32'h50, '0);
        refresh();
      end
    end
    wait_acks("bp_ack_seen", 1, 10);
    `CHK("bp_ack", arb_rdata_ack, 4'b1000)
    `CHK("bp_data", arb_rdata, ~32'h30)
    tick();
    `CHK("skip_pop", fifo_pop_o, 4'b0010)
    wait_acks("skip_ack_seen", 1, 10);
    `CHK("skip_ack", arb_rdata_ack, 4'b0010)
    `CHK("skip_data", arb_rdata, ~32'h50)
    `CHK("skip_pops", pop_ch.size(), 2)
    `CHK("skip_ch0_never", pop_ch[1], 1)
    tick();

    // Reset in the middle of a transaction: no ack for it
    clear_logs();
    push(2, 1'b0, 32'h60, '0);
    stall = 20;
    refresh();
    #1;
    tick();
    `CHK("mr_valid", slv_valid_o, 1'b1)
    PRESET = 1'b0;
    tick();
    `CHK("mr_valid_rst", slv_valid_o, 1'b0)
    `CHK("mr_grant_rst", grant_o, 2'd0)
    PRESET = 1'b1;
    stall  = 0;
    repeat (6) tick();
    `CHK("mr_no_ack", ack_ch.size(), 0)

    // Round robin with two entries per channel
    clear_logs();
    for (int e = 0; e < 2; e++)
      for (int k = 0; k < N_CH; k++) push(k, 1'b0, AW'(32'h1000 + k * 16 + e * 4), '0);
    refresh();
    #1;
    wait_acks("rr_drain", 8, 100);
    `CHK("rr_pops", pop_ch.size(), 8)
    for (int i = 0; i < 8; i++) begin
      exp_d = ~(32'h1000 + 32'(i % 4) * 16 + 32'(i / 4) * 4);
      checks++;
      if (pop_ch[i] !== (i % 4)) begin
        errors++;
        $error("FAIL rr_pop_order observed=%0h expected=%0h", pop_ch[i], i % 4);
      end
      checks++;
      if (ack_ch[i] !== (i % 4)) begin
        errors++;
        $error("FAIL rr_ack_order observed=%0h expected=%0h", ack_ch[i], i % 4);
      end
      checks++;
      if (ack_data[i] !== exp_d) begin
        errors++;
        $error("FAIL rr_data observed=%0h expected=%0h", ack_data[i], exp_d);
      end
      checks++;
      if (ack_err[i] !== 1'b0) begin
        errors++;
        $error("FAIL rr_err observed=%0h expected=0", ack_err[i]);
      end
      if (i > 0) begin
        checks++;
        if ((pop_cyc[i] - pop_cyc[i-1]) !== 4) begin
          errors++;
          $error("FAIL rr_spacing observed=%0d expected=4", pop_cyc[i] - pop_cyc[i-1]);
        end
      end
    end
    tick();

`ifdef ARB_TIMEOUT_EN
    // Slave never responds: error ack after the timeout, late response ignored
    clear_logs();
    push(0, 1'b0, 32'h70, '0);
    rsp_en = 1'b0;
    refresh();
    #1;
    wait_acks("to_ack_seen", 1, 20);
    `CHK("to_latency", cyc - pop_cyc[0], 9)
    `CHK("to_ack", arb_rdata_ack, 4'b0001)
    `CHK("to_data", arb_rdata, 32'hDEAD_0BAD)
    `CHK("to_err", arb_err_o, 1'b1)
    `CHK("to_valid", slv_valid_o, 1'b0)
    rsp_en = 1'b1;
    repeat (5) tick();
    `CHK("to_late_ignored", ack_ch.size(), 1)
    `CHK("to_err_clr", arb_err_o, 1'b0)
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
